fetch_unit: RTL and testbench

Instruction fetch front end for the SimpleRISC core. It sits directly upstream of the single-cycle datapath and replaces its combinational instruction-memory lookup. It issues in-order read requests to a variable-latency instruction memory and buffers the returned words with their PCs in a small queue. It hands them to the execute side through a valid/ready handshake. On a taken branch or return it flushes the queue and discards any responses still in flight.

---
 rtl/simplerisc_pkg.sv | 12 +
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions used by the fetch front end.
package simplerisc_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory request/response and instruction hand-off bundle of the fetch unit.
interface fetch_unit_if;
  import simplerisc_pkg::*;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Registered instruction queue holding {pc, word} pairs, with a synchronous flush.
module fetch_fifo
  import simplerisc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2 * XLEN,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // DEPTH is a power of two, so the pointers wrap naturally at their width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// In-order instruction fetch front end with credit-limited requests and redirect flush.
module fetch_unit
  import simplerisc_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  fetch_unit_if.master    bus
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [2*XLEN-1:0] fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_push;
  logic              fifo_pop;

  logic            req_valid;
  logic            issue;
  logic            rsp_dec;
  logic            credit_ok;
  logic [CW:0]     in_use;
  logic [XLEN-1:0] redirect_target;

  assign redirect_target = redirect_pc & ~XLEN'(3);
  assign in_use          = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign credit_ok       = in_use < (CW + 1)'(DEPTH);
  // Gated by reset so no request is presented while the unit is held in reset.
  assign req_valid = reset && (state_q == RUN) && !halt && !redirect_valid && credit_ok;
  assign issue     = req_valid && bus.mem_req_ready;
  assign rsp_dec   = bus.mem_rsp_valid && (outstanding_q != '0);
  assign fifo_pop  = bus.inst_ready && !fifo_empty && !redirect_valid;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    fifo_push     = 1'b0;
    outstanding_d = outstanding_q + CW'(issue) - CW'(rsp_dec);

    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      rsp_pc_d   = redirect_target;
      drop_cnt_d = outstanding_q - CW'(rsp_dec);
      state_d    = (drop_cnt_d != '0) ? FLUSH : RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (issue) fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
          if (bus.mem_rsp_valid && !fifo_full) begin
            fifo_push = 1'b1;
            rsp_pc_d  = rsp_pc_q + XLEN'(INST_BYTES);
          end
        end
        FLUSH: begin
          if (rsp_dec) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
            if (drop_cnt_q == CW'(1)) state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i ({rsp_pc_q, bus.mem_rsp_data}),
    .pop_i       (fifo_pop),
    .flush_i     (redirect_valid),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = fetch_pc_q;
  assign bus.inst_valid    = !fifo_empty;
  assign bus.inst_data     = fifo_empty ? '0 : fifo_head[XLEN-1:0];
  assign bus.inst_pc       = fifo_empty ? '0 : fifo_head[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with a latency-modelling instruction memory.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;

  fetch_unit_if bus ();

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount = 0;
  int cyc = 0;
  int lastDue = 0;
  int issueCount = 0;
  int consumedTotal = 0;
  exp_t expQ[$];
  mem_t memQ[$];
  logic [31:0] consumedLog[$];
  logic [31:0] modelFetchPc = '0;
  logic [31:0] firstIssueAddr = '0;
  bit firstIssueSeen = 0;

  int reqReadyPct = 100, instReadyPct = 100, haltPct = 0, redirPct = 0;
  int latMin = 1, latMax = 1;
  bit forceRedirect = 0;
  logic [31:0] forceTarget = '0;

  bit redirLast = 0, expectReqNext = 0, prevHold = 0;
  logic [31:0] prevPc = '0, prevData = '0;

  function automatic logic [31:0] memWord(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Holds the unit in reset and restarts the memory and reference models.
  task automatic doReset(input bit midCycle);
    if (midCycle) #2;
    else @(negedge clk);
    reset = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.inst_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data = '0;
    redirect_valid = 1'b0;
    halt = 1'b0;
    #1;
    if (midCycle) begin
      checkOutput("reset_inst_valid", bus.inst_valid, 0);
      checkOutput("reset_req_valid", bus.mem_req_valid, 0);
    end
    expQ.delete();
    memQ.delete();
    consumedLog.delete();
    modelFetchPc = 32'h0000_0000;
    lastDue = 0;
    redirLast = 0;
    expectReqNext = 0;
    prevHold = 0;
    firstIssueSeen = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One cycle of stimulus: memory response, random handshakes, then the issue/redirect model.
  task automatic applyStimulus();
    int lat;
    int due;
    @(negedge clk);
    cyc++;
    if (memQ.size() > 0 && memQ[0].due <= cyc) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data = memWord(memQ[0].addr);
      void'(memQ.pop_front());
    end else begin
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data = $urandom;
    end
    bus.mem_req_ready = ($urandom_range(99) < reqReadyPct);
    bus.inst_ready = ($urandom_range(99) < instReadyPct);
    halt = ($urandom_range(99) < haltPct);
    if (forceRedirect) begin
      redirect_valid = 1'b1;
      redirect_pc = forceTarget;
      forceRedirect = 0;
    end else if ($urandom_range(99) < redirPct) begin
      redirect_valid = 1'b1;
      redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
    end else begin
      redirect_valid = 1'b0;
    end
    #1;
    if (redirLast) begin
      checkOutput("redirect_inst_valid", bus.inst_valid, 0);
      if (expectReqNext && !halt && !redirect_valid)
        checkOutput("redirect_req_valid", bus.mem_req_valid, 1);
    end
    if (prevHold) begin
      checkOutput("hold_inst_pc", bus.inst_pc, prevPc);
      checkOutput("hold_inst_data", bus.inst_data, prevData);
    end
    if (halt) checkOutput("halt_req_valid", bus.mem_req_valid, 0);
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      checkOutput("req_addr", bus.mem_req_addr, modelFetchPc);
      checkOutput("credit_limit", expQ.size() < DEPTH, 1);
      expQ.push_back('{pc: modelFetchPc, data: memWord(modelFetchPc)});
      lat = $urandom_range(latMax, latMin);
      due = (cyc + lat > lastDue + 1) ? cyc + lat : lastDue + 1;
      lastDue = due;
      memQ.push_back('{addr: bus.mem_req_addr, due: due});
      if (!firstIssueSeen) begin
        firstIssueAddr = bus.mem_req_addr;
        firstIssueSeen = 1;
      end
      modelFetchPc = modelFetchPc + 32'd4;
      issueCount++;
    end
    redirLast = redirect_valid;
    if (redirect_valid) begin
      expQ.delete();
      consumedLog.delete();
      modelFetchPc = {redirect_pc[31:2], 2'b00};
      expectReqNext = (memQ.size() == 0);
    end
    prevHold = bus.inst_valid && !bus.inst_ready && !redirect_valid;
    prevPc = bus.inst_pc;
    prevData = bus.inst_data;
  endtask

  task automatic setKnobs(int rr, int ir, int hp, int rp, int lmin, int lmax);
    reqReadyPct = rr;
    instReadyPct = ir;
    haltPct = hp;
    redirPct = rp;
    latMin = lmin;
    latMax = lmax;
  endtask

  // Scoreboard monitor: every accepted instruction must be the oldest expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset && bus.inst_valid && bus.inst_ready && !redirect_valid) begin
        if (expQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL inst_spurious: got pc %h, expected no instruction", bus.inst_pc);
        end else begin
          e = expQ.pop_front();
          checkOutput("inst_pc", bus.inst_pc, e.pc);
          checkOutput("inst_data", bus.inst_data, e.data);
          consumedLog.push_back(bus.inst_pc);
          consumedTotal++;
        end
      end
    end
  end

  initial begin
    bus.mem_req_ready = 1'b0;
    bus.inst_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data = '0;
    #12;
    checkOutput("rst_req_valid", bus.mem_req_valid, 0);
    checkOutput("rst_req_addr", bus.mem_req_addr, 32'h0);
    checkOutput("rst_inst_valid", bus.inst_valid, 0);
    checkOutput("rst_inst_data", bus.inst_data, 32'h0);
    checkOutput("rst_inst_pc", bus.inst_pc, 32'h0);

    $display("[TB] streaming with 1-cycle memory");
    doReset(0);
    setKnobs(100, 100, 0, 0, 1, 1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      checkOutput("stream_req_valid", bus.mem_req_valid, 1);
    end
    checkOutput("stream_pc0", consumedLog[0], 32'h0);
    checkOutput("stream_pc1", consumedLog[1], 32'h4);
    checkOutput("stream_pc2", consumedLog[2], 32'h8);
    checkOutput("stream_pc3", consumedLog[3], 32'hC);

    $display("[TB] consumer stalled");
    doReset(0);
    setKnobs(100, 0, 0, 0, 1, 1);
    issueCount = 0;
    repeat (12) applyStimulus();
    checkOutput("stall_issue_count", issueCount, DEPTH);
    checkOutput("stall_req_valid", bus.mem_req_valid, 0);
    instReadyPct = 100;
    repeat (8) applyStimulus();
    checkOutput("stall_pc0", consumedLog[0], 32'h0);
    checkOutput("stall_pc1", consumedLog[1], 32'h4);
    checkOutput("stall_pc2", consumedLog[2], 32'h8);
    checkOutput("stall_pc3", consumedLog[3], 32'hC);

    $display("[TB] redirect with two responses in flight");
    doReset(0);
    setKnobs(100, 100, 0, 0, 3, 3);
    repeat (2) applyStimulus();
    checkOutput("flush_in_flight", memQ.size(), 2);
    forceRedirect = 1;
    forceTarget = 32'h0000_0103;
    repeat (15) applyStimulus();
    checkOutput("flush_pc0", consumedLog[0], 32'h100);
    checkOutput("flush_pc1", consumedLog[1], 32'h104);

    $display("[TB] address wrap");
    doReset(0);
    setKnobs(100, 100, 0, 0, 1, 1);
    forceRedirect = 1;
    forceTarget = 32'hFFFF_FFF8;
    repeat (12) applyStimulus();
    checkOutput("wrap_pc0", consumedLog[0], 32'hFFFF_FFF8);
    checkOutput("wrap_pc1", consumedLog[1], 32'hFFFF_FFFC);
    checkOutput("wrap_pc2", consumedLog[2], 32'h0000_0000);

    $display("[TB] reset while busy");
    doReset(0);
    setKnobs(100, 0, 0, 0, 3, 3);
    repeat (6) applyStimulus();
    checkOutput("busy_inst_valid", bus.inst_valid, 1);
    doReset(1);
    setKnobs(100, 100, 0, 0, 1, 1);
    repeat (3) applyStimulus();
    checkOutput("post_reset_first_req_seen", firstIssueSeen, 1);
    checkOutput("post_reset_first_req", firstIssueAddr, 32'h0);

    $display("[TB] randomized traffic");
    doReset(0);
    setKnobs(70, 70, 10, 3, 1, 4);
    consumedTotal = 0;
    repeat (3000) applyStimulus();
    checkOutput("random_progress", consumedTotal >= 300, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
